// File: rtl/drone_pkg.sv
// rtl/drone_pkg.sv - shared duty type, saturating add and default ESC PWM timing
package drone_pkg;

  typedef logic [7:0] duty_t;

  localparam int PERIOD_TICKS_DEF    = 1000000;
  localparam int MIN_PULSE_TICKS_DEF = 50000;
  localparam int STEP_TICKS_DEF      = 196;
  localparam int CNT_W_DEF           = 20;

  function automatic duty_t sat_add(input duty_t a, input duty_t b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one ESC output: active duty register, width compute, registered compare
module pwm_channel
  import drone_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int MIN_PULSE_TICKS = MIN_PULSE_TICKS_DEF,
  parameter int STEP_TICKS      = STEP_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  duty_t            staged_duty,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary,
  input  logic             arm_act,
  output logic             pwm
);

  duty_t            duty_q, duty_d;
  duty_t            duty_eff;
  logic [CNT_W-1:0] width;
  logic             pwm_q, pwm_d;

  // The boundary cycle forces the rising edge; later cycles compare against the
  // freshly loaded active duty, so the pulse spans counter values 0..width-1.
  always_comb begin
    duty_d   = duty_q;
    if (boundary) begin
      duty_d = staged_duty;
    end
    duty_eff = arm_act ? duty_q : '0;
    width    = CNT_W'(MIN_PULSE_TICKS) + CNT_W'(duty_eff) * CNT_W'(STEP_TICKS);
    pwm_d    = boundary || (cnt < width);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/motor_pwm_gen.sv
// rtl/motor_pwm_gen.sv - base throttle plus per-motor offsets into four double-buffered ESC PWM outputs
module motor_pwm_gen
  import drone_pkg::*;
#(
  parameter int PERIOD_TICKS    = PERIOD_TICKS_DEF,
  parameter int MIN_PULSE_TICKS = MIN_PULSE_TICKS_DEF,
  parameter int STEP_TICKS      = STEP_TICKS_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] throttle,
  input  logic [7:0] motor_1_offset,
  input  logic [7:0] motor_2_offset,
  input  logic [7:0] motor_3_offset,
  input  logic [7:0] motor_4_offset,
  input  logic       upd_valid,
  input  logic       arm,
  output logic       pwm_1,
  output logic       pwm_2,
  output logic       pwm_3,
  output logic       pwm_4,
  output logic       frame_start,
  output logic       armed
);

  if (MIN_PULSE_TICKS + 255 * STEP_TICKS >= PERIOD_TICKS) begin : g_bad_timing
    $error("motor_pwm_gen: maximum pulse leaves no low phase in the frame");
  end
  if (((PERIOD_TICKS - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("motor_pwm_gen: CNT_W too narrow for PERIOD_TICKS");
  end
  if (MIN_PULSE_TICKS < 1) begin : g_bad_min
    $error("motor_pwm_gen: MIN_PULSE_TICKS must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  duty_t            staged_q [4];
  duty_t            staged_d [4];
  duty_t            offset   [4];
  logic             arm_act_q, arm_act_d;
  logic             frame_start_q, frame_start_d;
  logic             boundary;
  logic [3:0]       pwm_w;

  assign offset[0] = motor_1_offset;
  assign offset[1] = motor_2_offset;
  assign offset[2] = motor_3_offset;
  assign offset[3] = motor_4_offset;

  assign boundary = (cnt_q == '0);

  always_comb begin
    cnt_d         = (cnt_q == CNT_W'(PERIOD_TICKS - 1)) ? '0 : cnt_q + CNT_W'(1);
    arm_act_d     = boundary ? arm : arm_act_q;
    frame_start_d = boundary;
    for (int i = 0; i < 4; i++) begin
      staged_d[i] = upd_valid ? sat_add(throttle, offset[i]) : staged_q[i];
    end
  end

  // Staging may update on the boundary edge itself; channels latch the old
  // staged value on that edge, so the new one lands a frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      arm_act_q     <= 1'b0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        staged_q[i] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      arm_act_q     <= arm_act_d;
      frame_start_q <= frame_start_d;
      for (int i = 0; i < 4; i++) begin
        staged_q[i] <= staged_d[i];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    pwm_channel #(
      .CNT_W          (CNT_W),
      .MIN_PULSE_TICKS(MIN_PULSE_TICKS),
      .STEP_TICKS     (STEP_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .staged_duty(staged_q[g]),
      .cnt        (cnt_q),
      .boundary   (boundary),
      .arm_act    (arm_act_q),
      .pwm        (pwm_w[g])
    );
  end

  assign pwm_1       = pwm_w[0];
  assign pwm_2       = pwm_w[1];
  assign pwm_3       = pwm_w[2];
  assign pwm_4       = pwm_w[3];
  assign frame_start = frame_start_q;
  assign armed       = arm_act_q;

endmodule
